// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with an integrated
// pending-write scoreboard for the ID/EX boundary.
//   - two combinational read ports, one clocked write port
//   - per-register busy bits set at issue, cleared at writeback
//   - combinational stall on RAW (rs1/rs2) and WAW (issue_rd) hazards
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback
// port into the read ports and into the hazard check in the same cycle.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] rs2_value,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] indata,
  input  logic            RegWrite,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wr,
  input  logic            use_rs1,
  input  logic            use_rs2,
  output logic            stall,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     pend_cnt
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;

  logic wr_en;      // data actually lands in the array
  logic set_en;     // a busy mark is placed for issue_rd
  logic waw_busy;   // effective busy state of issue_rd
  logic raw1, raw2, waw;
  logic inc, dec;

  // True for the hardwired zero register when that feature is enabled.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_en = RegWrite && !is_zero(rd);

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wr_en && (rd == rs1);
  assign fwd2 = wr_en && (rd == rs2);

  // Read ports see the writeback data in the writeback cycle itself.
  always_comb begin
    rs1_value = is_zero(rs1) ? '0 : (fwd1 ? indata : regs_q[rs1]);
    rs2_value = is_zero(rs2) ? '0 : (fwd2 ? indata : regs_q[rs2]);
  end

  assign rs1_busy = busy_q[rs1] && !fwd1;
  assign rs2_busy = busy_q[rs2] && !fwd2;
  assign waw_busy = busy_q[issue_rd] && !(RegWrite && (rd == issue_rd));
`else
  // Read ports return the array as it stands before this cycle's write.
  always_comb begin
    rs1_value = is_zero(rs1) ? '0 : regs_q[rs1];
    rs2_value = is_zero(rs2) ? '0 : regs_q[rs2];
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
  assign waw_busy = busy_q[issue_rd];
`endif

  assign raw1  = use_rs1 && rs1_busy;
  assign raw2  = use_rs2 && rs2_busy;
  assign waw   = issue_wr && waw_busy;
  assign stall = issue_valid && (raw1 || raw2 || waw);

  assign set_en = issue_valid && !stall && issue_wr && !is_zero(issue_rd);

  // The counter follows actual bit flips, so it always equals the
  // population of busy. A set and a clear of the same busy register
  // cancel out (the younger issue keeps the mark).
  assign inc = set_en && !busy_q[issue_rd];
  assign dec = RegWrite && busy_q[rd] && !(set_en && (issue_rd == rd));

  // Next busy vector: clear on writeback first, then set on issue so the
  // younger instruction wins on a same-register collision.
  // NOTE: every always_comb output gets a default assignment on entry so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (RegWrite) busy_d[rd]       = 1'b0;
    if (set_en)   busy_d[issue_rd] = 1'b1;
    pend_cnt_d = pend_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  // Scoreboard state.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Register array write port.
  // NOTE: the array is reset here because reads after reset must return
  // zero; this forces flops rather than a RAM macro for the storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= indata;
    end
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb (default
// parameters). Stimulus pushes expected values into a queue; a monitor
// pops and compares them on the falling clock edge. Expectations follow
// REGFILE_BYPASS_EN when the bench is built with that macro.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST;
  logic [AW-1:0]   rs1, rs2, rd, issue_rd;
  logic [XLEN-1:0] rs1_value, rs2_value, indata;
  logic            RegWrite, issue_valid, issue_wr, use_rs1, use_rs2;
  logic            stall, rs1_busy, rs2_busy;
  logic [AW:0]     pend_cnt;

  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST),
    .rs1(rs1), .rs2(rs2), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rd(rd), .indata(indata), .RegWrite(RegWrite),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .use_rs1(use_rs1), .use_rs2(use_rs2),
    .stall(stall), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pend_cnt(pend_cnt)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [2:0] {S_V1, S_V2, S_STALL, S_PEND, S_B1, S_B2} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    exp_q.push_back(c);
  endtask

  // Monitor: drain all expectations queued during this cycle.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = exp_q.pop_front();
      case (c.sel)
        S_V1:    act = rs1_value;
        S_V2:    act = rs2_value;
        S_STALL: act = {31'b0, stall};
        S_PEND:  act = 32'(pend_cnt);
        S_B1:    act = {31'b0, rs1_busy};
        default: act = {31'b0, rs2_busy};
      endcase
      cmp_cnt++;
      if (act !== c.exp) begin
        fail_cnt++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
      end
    end
  end

  task automatic idle();
    RegWrite = 0; rd = '0; indata = '0;
    issue_valid = 0; issue_wr = 0; issue_rd = '0;
    use_rs1 = 0; use_rs2 = 0; rs1 = '0; rs2 = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    // Reset held with an active write and issue: nothing may land.
    RST = 1; RegWrite = 1; rd = 5'd3; indata = 32'hDEAD;
    rs1 = 5'd3; rs2 = 5'd3; issue_valid = 1; issue_wr = 1; issue_rd = 5'd4; use_rs1 = 1;
    #1;
    expect_val("rst_v1", S_V1, 0);
    expect_val("rst_v2", S_V2, 0);
    expect_val("rst_pend", S_PEND, 0);
    expect_val("rst_stall", S_STALL, 0);
    tick(); tick();
    expect_val("rst_hold_pend", S_PEND, 0);
    expect_val("rst_hold_v1", S_V1, 0);
    RST = 0; idle(); rs1 = 5'd3;
    expect_val("rst_no_write", S_V1, 0);
    tick();
    RegWrite = 1; rd = 5'd3; indata = 32'h32; rs1 = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_val("wr_same_cycle", S_V1, 32'h32);
`else
    expect_val("wr_same_cycle", S_V1, 0);
`endif
    tick();
    idle(); rs1 = 5'd3;
    expect_val("wr_after_edge", S_V1, 32'h32);

    // Zero register.
    tick();
    RegWrite = 1; rd = 5'd0; indata = 32'hFFFF_FFFF;
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'd0; rs1 = 5'd0;
    expect_val("x0_read", S_V1, 0);
    expect_val("x0_issue_stall", S_STALL, 0);
    tick();
    idle(); rs1 = 5'd0; use_rs1 = 1;
    expect_val("x0_pend", S_PEND, 0);
    expect_val("x0_busy", S_B1, 0);

    // RAW on rs1.
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'd5;
    expect_val("raw_first_issue", S_STALL, 0);
    tick();
    idle(); rs1 = 5'd5;
    expect_val("raw_pend1", S_PEND, 1);
    expect_val("raw_busy5", S_B1, 1);
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'd6; use_rs1 = 1; rs1 = 5'd5;
    expect_val("raw_stall", S_STALL, 1);
    tick();
    expect_val("raw_no_state", S_PEND, 1);
    RegWrite = 1; rd = 5'd5; indata = 32'h10;
`ifdef REGFILE_BYPASS_EN
    expect_val("raw_wb_stall", S_STALL, 0);
    expect_val("raw_wb_fwd", S_V1, 32'h10);
    tick();
`else
    expect_val("raw_wb_stall", S_STALL, 1);
    expect_val("raw_wb_old", S_V1, 0);
    tick();
    RegWrite = 0;
    expect_val("raw_retry_stall", S_STALL, 0);
    expect_val("raw_retry_val", S_V1, 32'h10);
    tick();
`endif
    idle(); rs2 = 5'd6;
    expect_val("raw_pend_after", S_PEND, 1);
    expect_val("raw_busy6", S_B2, 1);
    tick();
    RegWrite = 1; rd = 5'd6; indata = 32'h66;
    tick();
    idle();
    expect_val("raw_drained", S_PEND, 0);

    // WAW on issue_rd.
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'd7;
    tick();
    expect_val("waw_stall_a", S_STALL, 1);
    tick();
    expect_val("waw_stall_b", S_STALL, 1);
    expect_val("waw_pend", S_PEND, 1);
    RegWrite = 1; rd = 5'd7; indata = 32'h77;
`ifdef REGFILE_BYPASS_EN
    expect_val("waw_wb_stall", S_STALL, 0);
    tick();
`else
    expect_val("waw_wb_stall", S_STALL, 1);
    tick();
    RegWrite = 0;
    expect_val("waw_retry_stall", S_STALL, 0);
    tick();
`endif
    idle(); rs1 = 5'd7;
    expect_val("waw_pend_after", S_PEND, 1);
    expect_val("waw_data", S_V1, 32'h77);
    tick();
    RegWrite = 1; rd = 5'd7; indata = 32'h78;
    tick();
    idle();
    expect_val("waw_drained", S_PEND, 0);

    // Same-edge set and clear of register 9.
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'd9;
    tick();
    idle();
    expect_val("sc_pend1", S_PEND, 1);
    RegWrite = 1; rd = 5'd9; indata = 32'h99;
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd9;
`ifdef REGFILE_BYPASS_EN
    expect_val("sc_issue_stall", S_STALL, 0);
    tick();
    idle(); rs1 = 5'd9;
    expect_val("sc_busy9", S_B1, 1);
    expect_val("sc_pend_same", S_PEND, 1);
    tick();
    RegWrite = 1; rd = 5'd9; indata = 32'h9A;
    tick();
`else
    expect_val("sc_issue_stall", S_STALL, 1);
    tick();
`endif
    idle(); rs1 = 5'd9;
    expect_val("sc_cleared", S_B1, 0);
    expect_val("sc_drained", S_PEND, 0);

    // Fill all 31 writable destinations.
    for (int i = 1; i < 32; i++) begin
      tick();
      idle(); issue_valid = 1; issue_wr = 1; issue_rd = AW'(i);
      expect_val($sformatf("fill_stall_%0d", i), S_STALL, 0);
    end
    tick();
    idle(); use_rs2 = 1; rs2 = 5'd20; issue_valid = 1;
    expect_val("fill_pend", S_PEND, 31);
    expect_val("fill_rs2_busy", S_B2, 1);
    expect_val("fill_rs2_stall", S_STALL, 1);
    for (int i = 1; i < 32; i++) begin
      tick();
      idle(); RegWrite = 1; rd = AW'(i); indata = 32'(i) * 32'h101;
      if (i == 16) expect_val("drain_half", S_PEND, 16);
    end
    tick();
    idle(); rs1 = 5'd20; rs2 = 5'd31;
    expect_val("drain_pend", S_PEND, 0);
    expect_val("drain_v20", S_V1, 32'h1414);
    expect_val("drain_v31", S_V2, 32'h1F1F);

    // Refill partly, then reset asynchronously mid-sequence.
    for (int i = 1; i <= 10; i++) begin
      tick();
      idle(); issue_valid = 1; issue_wr = 1; issue_rd = AW'(i);
    end
    tick();
    idle();
    expect_val("refill_pend", S_PEND, 10);
    tick();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd11; use_rs1 = 1; rs1 = 5'd2;
    RegWrite = 1; rd = 5'd20; indata = 32'h5555; rs2 = 5'd20;
    #2 RST = 1;
    #1;
    expect_val("mid_rst_pend", S_PEND, 0);
    expect_val("mid_rst_busy", S_B1, 0);
    expect_val("mid_rst_stall", S_STALL, 0);
    expect_val("mid_rst_v2", S_V2, 0);
    tick();
    RST = 0; idle(); rs1 = 5'd20; rs2 = 5'd3;
    tick();
    expect_val("post_rst_pend", S_PEND, 0);
    expect_val("post_rst_lost_wr", S_V1, 0);
    expect_val("post_rst_v3", S_V2, 0);

    // Let the monitor drain, bounded.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      fail_cnt++;
      $display("FAIL drain_timeout: %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated pending-write scoreboard for the ID/EX boundary of the pipeline. It provides two combinational read ports and one clocked write port, with x0 optionally hardwired to zero. It tracks which destination registers have an in-flight write and raises a stall when an issuing instruction would read or overwrite a pending register. It replaces the fixed 32x32 regfile and moves hazard detection out of the decode glue logic.

## Interface
Parameters:
- XLEN, 32, data width in bits
- AW, 5, register address width; register count NREG = 2**AW
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never marked busy

Ports:
- CLK  in  1  clock, rising-edge active
- RST  in  1  asynchronous, active-high reset
- rs1  in  AW  read address, port 1
- rs2  in  AW  read address, port 2
- rs1_value  out  XLEN  read data, port 1 (combinational)
- rs2_value  out  XLEN  read data, port 2 (combinational)
- rd  in  AW  writeback address
- indata  in  XLEN  writeback data
- RegWrite  in  1  writeback enable
- issue_valid  in  1  decode is issuing an instruction this cycle
- issue_rd  in  AW  destination of the issuing instruction
- issue_wr  in  1  issuing instruction writes issue_rd
- use_rs1  in  1  issuing instruction reads rs1
- use_rs2  in  1  issuing instruction reads rs2
- stall  out  1  issue refused this cycle (combinational)
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- pend_cnt  out  AW+1  number of registers currently marked busy

## Operation
- Storage: NREG x XLEN array (regs) and NREG busy bits (busy).
- Read: rsN_value = regs[rsN]. If ZERO_REG=1 and rsN==0, the output is 0.
- Write: on the rising edge of CLK, when RegWrite=1, regs[rd] <= indata. The write is dropped if ZERO_REG=1 and rd==0.
- Busy clear: on the same edge, when RegWrite=1, busy[rd] <= 0.
- Hazard terms:
  - raw1 = use_rs1 & rs1_busy
  - raw2 = use_rs2 & rs2_busy
  - waw = issue_wr & busy_eff[issue_rd]
- Stall: stall = issue_valid & (raw1 | raw2 | waw).
- Busy set: when issue_valid & ~stall & issue_wr, busy[issue_rd] <= 1. The set is skipped if ZERO_REG=1 and issue_rd==0.
- Simultaneous set and clear of the same register on one edge: set wins, because the issuing instruction is younger.
- pend_cnt tracks the population of busy:
  - +1 on a set of a non-busy register
  - -1 on a clear of a busy register
  - unchanged if both happen on the same register, or if neither changes a bit
  - never exceeds NREG and never wraps
- A stalled issue changes no state. Decode holds its inputs and retries.
- RegWrite to a register that is not busy is legal. The data is written and busy is unchanged.

## Timing
- Reset (RST=1, asynchronous): all regs = 0, all busy = 0, pend_cnt = 0. Consequently rs1_value = rs2_value = 0, rs1_busy = rs2_busy = 0 and stall = 0 while reset is held.
- Reset asserted mid-operation discards all pending marks immediately. Writes in the same cycle are lost.
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge. Data written at edge N is visible on reads after edge N.
- busy_eff and rsN_busy are defined by the bypass configuration (see Configuration).
- stall is combinational from the current inputs and current state. There is no registered handshake.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Same-cycle write-to-read forwarding: if RegWrite & rd==rsN (and not x0 with ZERO_REG=1), then rsN_value = indata and rsN_busy = 0.
  - busy_eff[issue_rd] is likewise 0 when RegWrite & rd==issue_rd.
  - An instruction waiting on a writeback issues in the writeback cycle itself.
- Not defined:
  - Reads return the pre-write array contents.
  - busy_eff = busy, so a dependent instruction stalls through the writeback cycle and issues one cycle later.

## Test plan
- Reset: hold RST=1 for 2 cycles while RegWrite=1 -> rs1_value=rs2_value=0, pend_cnt=0, no write lands. Release, write rd=3/indata=0x32 -> reading rs1=3 returns 0x32 after the edge.
- Zero register: RegWrite rd=0/indata=0xFFFFFFFF, then issue issue_rd=0 issue_wr=1 -> rs1=0 reads 0, pend_cnt stays 0, stall=0.
- RAW stall: issue issue_rd=5 -> pend_cnt=1. Next cycle issue with rs1=5, use_rs1=1 -> stall=1 and no state change. Writeback rd=5/indata=0x10:
  - bypass on: stall=0 in the writeback cycle and rs1_value=0x10
  - bypass off: stall=1 in the writeback cycle, 0 on the following cycle
- WAW: issue_rd=7 pending, second issue with issue_rd=7, issue_wr=1 -> stall=1 until RegWrite rd=7.
- Simultaneous set/clear: busy[9]=1, with RegWrite rd=9 and a non-stalled issue issue_rd=9 on the same edge -> busy[9]=1 and pend_cnt unchanged.
- Fill/count: issue 31 distinct destinations 1..31 (AW=5, ZERO_REG=1) -> pend_cnt=31. Write back all 31 -> pend_cnt=0. Assert RST mid-sequence -> pend_cnt=0 immediately.
